// File: rtl/lif_tdm_if.sv
// Host-side bus of the LIF TDM scheduler: current writes, state readback, sweep status and spikes.
interface lif_tdm_if #(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = 2
);
  logic                 tick;
  logic                 cur_we;
  logic [IDX_W-1:0]     cur_addr;
  logic [7:0]           cur_data;
  logic [IDX_W-1:0]     state_sel;
  logic [7:0]           state_out;
  logic                 busy;
  logic                 done;
  logic                 spike_valid;
  logic [IDX_W-1:0]     spike_idx;
  logic [N_NEURONS-1:0] spike_vec;
  logic                 tick_overrun;

  modport master (
    output tick, cur_we, cur_addr, cur_data, state_sel,
    input  state_out, busy, done, spike_valid, spike_idx, spike_vec, tick_overrun
  );
  modport slave (
    input  tick, cur_we, cur_addr, cur_data, state_sel,
    output state_out, busy, done, spike_valid, spike_idx, spike_vec, tick_overrun
  );
endinterface

// File: rtl/lif_tdm_scheduler.sv
// Round-robin LIF scheduler: one shared leak/integrate/fire step visits each virtual neuron
// once per tick, one neuron per clock.
module lif_tdm_scheduler #(
  parameter int N_NEURONS    = 4,
  parameter int IDX_W        = 2,
  parameter int THRESHOLD    = 200,
  parameter int LEAK_SHIFT   = 1,
  parameter int REFRAC_TICKS = 2,
  parameter int REFRAC_W     = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  lif_tdm_if.slave  bus
);
  typedef enum logic {IDLE, SWEEP} fsm_e;

  localparam logic [8:0]          THR9   = 9'(THRESHOLD);
  localparam logic [REFRAC_W-1:0] R_LOAD = REFRAC_W'(REFRAC_TICKS);
  localparam logic [IDX_W-1:0]    LAST   = IDX_W'(N_NEURONS - 1);

  fsm_e                               fsm_q, fsm_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [N_NEURONS-1:0][7:0]          mem_q, mem_d;
  logic [N_NEURONS-1:0][7:0]          cur_q, cur_d;
  logic [N_NEURONS-1:0][REFRAC_W-1:0] ref_q, ref_d;
  logic                               done_q, done_d;
  logic                               sv_q, sv_d;
  logic [IDX_W-1:0]                   sidx_q, sidx_d;
  logic [N_NEURONS-1:0]               svec_q, svec_d;
  logic                               ovr_q, ovr_d;

  // Shared datapath operating on the neuron selected by idx_q
  logic [7:0]          s_cur, c_cur, leak, v_sat;
  logic [8:0]          v;
  logic [REFRAC_W-1:0] r_cur;
  logic                in_refrac, fire;

  always_comb begin
    s_cur     = mem_q[idx_q];
    c_cur     = cur_q[idx_q];
    r_cur     = ref_q[idx_q];
    leak      = s_cur >> LEAK_SHIFT;
    v         = {1'b0, s_cur} - {1'b0, leak} + {1'b0, c_cur};
    v_sat     = v[8] ? 8'hFF : v[7:0];
    in_refrac = (r_cur != '0);
    fire      = !in_refrac && ({1'b0, v_sat} >= THR9);
  end

  always_comb begin
    fsm_d  = fsm_q;
    idx_d  = idx_q;
    mem_d  = mem_q;
    cur_d  = cur_q;
    ref_d  = ref_q;
    done_d = 1'b0;
    sv_d   = 1'b0;
    sidx_d = sidx_q;
    svec_d = svec_q;
    ovr_d  = ovr_q;
    case (fsm_q)
      IDLE: begin
        if (bus.tick) begin
          fsm_d  = SWEEP;
          idx_d  = '0;
          svec_d = '0;
        end
      end
      SWEEP: begin
        if (bus.tick) ovr_d = 1'b1;
        if (in_refrac) begin
          mem_d[idx_q] = 8'd0;
          ref_d[idx_q] = r_cur - REFRAC_W'(1);
        end else if (fire) begin
          mem_d[idx_q]  = 8'd0;
          ref_d[idx_q]  = R_LOAD;
          sv_d          = 1'b1;
          sidx_d        = idx_q;
          svec_d[idx_q] = 1'b1;
        end else begin
          mem_d[idx_q] = v_sat;
        end
        if (idx_q == LAST) begin
          fsm_d  = IDLE;
          done_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: fsm_d = IDLE;
    endcase
    // Host write lands after the update read cur_q, so a same-edge collision affects the next sweep
    if (bus.cur_we) cur_d[bus.cur_addr] = bus.cur_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      idx_q  <= '0;
      mem_q  <= '0;
      cur_q  <= '0;
      ref_q  <= '0;
      done_q <= 1'b0;
      sv_q   <= 1'b0;
      sidx_q <= '0;
      svec_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      idx_q  <= idx_d;
      mem_q  <= mem_d;
      cur_q  <= cur_d;
      ref_q  <= ref_d;
      done_q <= done_d;
      sv_q   <= sv_d;
      sidx_q <= sidx_d;
      svec_q <= svec_d;
      ovr_q  <= ovr_d;
    end
  end

  assign bus.state_out    = mem_q[bus.state_sel];
  assign bus.busy         = (fsm_q == SWEEP);
  assign bus.done         = done_q;
  assign bus.spike_valid  = sv_q;
  assign bus.spike_idx    = sidx_q;
  assign bus.spike_vec    = svec_q;
  assign bus.tick_overrun = ovr_q;
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Randomized + directed bench for lif_tdm_scheduler against a per-sweep behavioural LIF model.
module tb_lif_tdm_scheduler;
  localparam int N = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lif_tdm_if #(.N_NEURONS(N), .IDX_W(IW)) bus();

  lif_tdm_scheduler #(
    .N_NEURONS(N), .IDX_W(IW), .THRESHOLD(200), .LEAK_SHIFT(1),
    .REFRAC_TICKS(2), .REFRAC_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: neuron arrays plus sweep position (-1 = idle)
  int       m_st[N];
  int       m_cur[N];
  int       m_ref[N];
  int       m_pos;
  bit       m_done, m_sv, m_ovr;
  int       m_sidx;
  bit [N-1:0] m_svec;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_cur[i] = 0; m_ref[i] = 0;
    end
    m_pos = -1; m_done = 0; m_sv = 0; m_ovr = 0; m_sidx = 0; m_svec = '0;
  endtask

  task automatic model_update(input int i);
    int v;
    if (m_ref[i] != 0) begin
      m_st[i] = 0;
      m_ref[i]--;
    end else begin
      v = m_st[i] - m_st[i] / 2 + m_cur[i];
      if (v > 255) v = 255;
      if (v >= 200) begin
        m_st[i] = 0; m_ref[i] = 2;
        m_sv = 1; m_sidx = i; m_svec[i] = 1'b1;
      end else begin
        m_st[i] = v;
      end
    end
  endtask

  task automatic check_outs();
    logic [IW-1:0] sel;
    chk("busy", 32'(bus.busy), 32'(m_pos >= 0));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("spike_valid", 32'(bus.spike_valid), 32'(m_sv));
    if (m_sv) chk("spike_idx", 32'(bus.spike_idx), 32'(m_sidx));
    chk("spike_vec", 32'(bus.spike_vec), 32'(m_svec));
    chk("tick_overrun", 32'(bus.tick_overrun), 32'(m_ovr));
    sel = IW'($urandom_range(N - 1));
    bus.state_sel = sel;
    #1;
    chk("state_out", 32'(bus.state_out), 32'(m_st[sel]));
  endtask

  // One clock: model consumes the inputs present before the edge, then outputs are compared.
  task automatic cycle();
    m_done = 0; m_sv = 0;
    if (m_pos < 0) begin
      if (bus.tick) begin m_pos = 0; m_svec = '0; end
    end else begin
      if (bus.tick) m_ovr = 1;
      model_update(m_pos);
      m_pos++;
      if (m_pos == N) begin m_pos = -1; m_done = 1; end
    end
    if (bus.cur_we) m_cur[bus.cur_addr] = int'(bus.cur_data);
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_sv", 32'(bus.spike_valid), 0);
    chk("rst_sidx", 32'(bus.spike_idx), 0);
    chk("rst_svec", 32'(bus.spike_vec), 0);
    chk("rst_ovr", 32'(bus.tick_overrun), 0);
    for (int i = 0; i < N; i++) begin
      bus.state_sel = IW'(i);
      #1;
      chk("rst_state", 32'(bus.state_out), 0);
    end
    @(negedge clk);
    bus.tick = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic wr(input int a, input int d);
    bus.cur_we = 1'b1; bus.cur_addr = IW'(a); bus.cur_data = 8'(d);
    cycle();
    bus.cur_we = 1'b0;
  endtask

  task automatic sweep();
    bus.tick = 1'b1;
    cycle();
    bus.tick = 1'b0;
    repeat (N) cycle();
  endtask

  task automatic peek(input string tag, input int i, input int exp);
    bus.state_sel = IW'(i);
    #1;
    chk(tag, 32'(bus.state_out), 32'(exp));
  endtask

  int exp_int[11] = '{100, 150, 175, 188, 194, 197, 199, 0, 0, 0, 100};

  initial begin
    bus.tick = 1'b1; bus.cur_we = 1'b0; bus.cur_addr = '0; bus.cur_data = '0; bus.state_sel = '0;
    model_reset();

    // Reset held with tick asserted across edges
    #12;
    do_reset();
    cycle();

    // Integration / spike / refractory on neuron 0
    wr(0, 100);
    for (int t = 0; t < 11; t++) begin
      sweep();
      peek("int_state0", 0, exp_int[t]);
      if (t == 7) chk("int_spike_vec", 32'(bus.spike_vec), 32'h1);
    end

    // Two neurons spike in the same sweep
    do_reset();
    wr(1, 255);
    wr(3, 255);
    sweep();
    chk("multi_spike_vec", 32'(bus.spike_vec), 32'hA);

    // Overrun: second tick two cycles into the sweep
    do_reset();
    wr(2, 30);
    bus.tick = 1'b1; cycle();
    bus.tick = 1'b0; cycle();
    bus.tick = 1'b1; cycle();
    bus.tick = 1'b0;
    repeat (N - 2) cycle();
    chk("ovr_set", 32'(bus.tick_overrun), 1);
    cycle();
    chk("ovr_idle_after", 32'(bus.busy), 0);
    sweep();
    chk("ovr_sticky", 32'(bus.tick_overrun), 1);

    // Back-to-back tick in the done cycle is accepted
    bus.tick = 1'b1; cycle();
    bus.tick = 1'b0;
    repeat (N) cycle();

    // Write collision with neuron 2's update edge
    do_reset();
    wr(2, 50);
    bus.tick = 1'b1; cycle();
    bus.tick = 1'b0;
    cycle(); cycle();
    bus.cur_we = 1'b1; bus.cur_addr = 2'd2; bus.cur_data = 8'd120;
    cycle();
    bus.cur_we = 1'b0;
    repeat (N - 3) cycle();
    peek("coll_first", 2, 50);
    sweep();
    peek("coll_second", 2, 145);

    // Reset in the middle of a sweep
    wr(1, 255);
    bus.tick = 1'b1; cycle();
    bus.tick = 1'b0;
    cycle(); cycle();
    do_reset();
    repeat (N + 2) cycle();

    // Random traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      bus.tick     = ($urandom_range(3) == 0);
      bus.cur_we   = ($urandom_range(2) == 0);
      bus.cur_addr = IW'($urandom_range(N - 1));
      bus.cur_data = 8'($urandom_range(255));
      cycle();
      if (k == 1500) do_reset();
    end
    bus.tick = 1'b0; bus.cur_we = 1'b0;
    repeat (N + 2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
